// File: rtl/register_bank_dump_if.sv
// Dump-engine handshake bundle between the register bank and the debug/UART unit.
interface register_bank_dump_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic              i_dump_start;
  logic              i_dump_ready;
  logic              o_dump_valid;
  logic [NB_REG-1:0] o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;
  logic              o_dump_last;
  logic              o_dump_done;
  logic              o_busy;

  // master = debug unit (consumer), slave = register bank (producer)
  modport master (
    output i_dump_start, i_dump_ready,
    input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_last, o_dump_done, o_busy
  );
  modport slave (
    input  i_dump_start, i_dump_ready,
    output o_dump_valid, o_dump_addr, o_dump_data, o_dump_last, o_dump_done, o_busy
  );
endinterface

// File: rtl/register_bank_dump.sv
// ID-stage register file: two combinational read ports, one write port, optional
// hardwired zero / write bypass, and a handshaked engine that streams all registers out.
module register_bank_dump #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_REG-1:0]  i_read_reg1,
  input  logic [NB_REG-1:0]  i_read_reg2,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic               i_write_enable,
  output logic [NB_DATA-1:0] o_register1,
  output logic [NB_DATA-1:0] o_register2,
  register_bank_dump_if.slave dump
);
  localparam int DEPTH = 1 << NB_REG;
  localparam logic [NB_REG-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  logic [NB_DATA-1:0] regs_q [DEPTH];
  logic [NB_DATA-1:0] regs_d [DEPTH];
  logic               wr_ok;
  logic [NB_REG-1:0]  rd_addr [2];
  logic [NB_DATA-1:0] rd_data [2];

  state_e             state_q;
  logic [NB_REG-1:0]  ptr_q;
  logic [NB_DATA-1:0] data_q;
  logic               valid_q, last_q, done_q, busy_q;
  logic [NB_REG-1:0]  nxt_addr;
  logic [NB_DATA-1:0] snap_data;

  assign wr_ok = i_write_enable && !(ZERO_REG && (i_write_reg == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[i_write_reg] = i_write_data;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_addr[0] = i_read_reg1;
  assign rd_addr[1] = i_read_reg2;

  // zero-register and reset override win over bypass
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (BYPASS && wr_ok && (i_write_reg == rd_addr[p])) rd_data[p] = i_write_data;
      if ((ZERO_REG && (rd_addr[p] == '0)) || !i_reset) rd_data[p] = '0;
    end
  end

  assign o_register1 = rd_data[0];
  assign o_register2 = rd_data[1];

  // Beats snapshot the post-edge register value, so a write on the loading edge lands in the beat.
  always_comb begin
    nxt_addr  = (state_q == IDLE) ? '0 : ptr_q + NB_REG'(1);
    snap_data = regs_d[nxt_addr];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (dump.i_dump_start) begin
            state_q <= SEND;
            ptr_q   <= nxt_addr;
            data_q  <= snap_data;
            valid_q <= 1'b1;
            last_q  <= (nxt_addr == LAST);
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (dump.i_dump_ready) begin
            if (ptr_q == LAST) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= nxt_addr;
              data_q  <= snap_data;
              last_q  <= (nxt_addr == LAST);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump.o_dump_valid = valid_q;
  assign dump.o_dump_addr  = ptr_q;
  assign dump.o_dump_data  = data_q;
  assign dump.o_dump_last  = last_q;
  assign dump.o_dump_done  = done_q;
  assign dump.o_busy       = busy_q;
endmodule
